v_tile_writer: RTL and testbench

- Producer-side counterpart of the v_tile write ports; the initiator of the write_en/write_rdy/write_ack handshake.
- Accepts finished vector results (data, 4-bit dest_info, one-cycle valid strobe equal to a tile's adder_ack) into a small FIFO.
- Forwards each result to the downstream tile's vector port 1, vector port 2 or scalar config port 3, as selected by dest_info.
- Sits between tiles in the CGRA fabric so adder results chain into the next tile without testbench intervention.

---
 rtl/v_tile_writer_if.sv | 38 +++
 rtl/v_tile_writer.sv | 224 ++++++++++++++++++++++
 tb/tb_v_tile_writer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_tile_writer_if.sv
// Downstream write bus between a v_tile_writer (master) and a tile's write
// ports (slave): per-port request/ready/acknowledge plus the write data.
//   write_en1..3   : master -> slave, write request per port
//   w_data_out1/2  : master -> slave, vector data for ports 1/2
//   w_data_out3    : master -> slave, scalar config data for port 3
//   write_rdy1..3  : slave -> master, port ready
//   write_ack1..3  : slave -> master, write acknowledge
interface v_tile_writer_if #(
  parameter int unsigned width      = 16,
  parameter int unsigned num_inputs = 4
);
  logic             write_en1;
  logic             write_en2;
  logic             write_en3;
  logic [width-1:0] w_data_out1 [num_inputs];
  logic [width-1:0] w_data_out2 [num_inputs];
  logic [width-1:0] w_data_out3;
  logic             write_rdy1;
  logic             write_rdy2;
  logic             write_rdy3;
  logic             write_ack1;
  logic             write_ack2;
  logic             write_ack3;

  modport master (
    output write_en1, write_en2, write_en3,
    output w_data_out1, w_data_out2, w_data_out3,
    input  write_rdy1, write_rdy2, write_rdy3,
    input  write_ack1, write_ack2, write_ack3
  );

  modport slave (
    input  write_en1, write_en2, write_en3,
    input  w_data_out1, w_data_out2, w_data_out3,
    output write_rdy1, write_rdy2, write_rdy3,
    output write_ack1, write_ack2, write_ack3
  );
endinterface

// File: rtl/v_tile_writer.sv
// Producer-side writer for v_tile write ports. Finished result vectors are
// queued in a small FIFO and forwarded, strictly in order, to the downstream
// tile's vector port 1, vector port 2 or scalar config port 3 using the
// write_en / write_rdy / write_ack handshake. Route 3 discards the entry.
//   clk, reset  : clock, asynchronous active-high reset
//   in_valid    : one-cycle strobe qualifying in_data / in_dest
//   in_data     : result vector (num_inputs elements of width bits)
//   in_dest     : [1:0] route (0: port1, 1: port2, 2: port3, 3: drop), [3:2] ignored
//   in_ready    : FIFO not full
//   busy        : FIFO non-empty or a write in progress
//   overflow    : sticky, input arrived while the FIFO was full
//   drop_count  : saturating count of route-3 entries discarded
//   wr          : downstream write bus (master side)
module v_tile_writer #(
  parameter int unsigned width      = 16,
  parameter int unsigned num_inputs = 4,
  parameter int unsigned fifo_depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [width-1:0] in_data [num_inputs],
  input  logic [3:0]       in_dest,
  output logic             in_ready,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       drop_count,
  v_tile_writer_if.master  wr
);

  localparam int unsigned PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CNT_W = $clog2(fifo_depth + 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(fifo_depth);
  localparam logic [1:0]       ROUTE_DROP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_REL  = 2'd3
  } state_e;

  state_e           state_q,      state_d;
  logic [width-1:0] mem_data_q  [fifo_depth][num_inputs];
  logic [width-1:0] mem_data_d  [fifo_depth][num_inputs];
  logic [1:0]       mem_route_q [fifo_depth];
  logic [1:0]       mem_route_d [fifo_depth];
  logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0] count_q,      count_d;
  logic [width-1:0] data_q [num_inputs];
  logic [width-1:0] data_d [num_inputs];
  logic [1:0]       route_q,      route_d;
  logic [2:0]       wen_q,        wen_d;
  logic             in_ready_q,   in_ready_d;
  logic             busy_q,       busy_d;
  logic             overflow_q,   overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic full_c;
  logic push_c;
  logic pop_c;
  logic sel_rdy_c;
  logic sel_ack_c;
  logic unused_dest_c;

  // Reserved destination bits carry no meaning here.
  assign unused_dest_c = ^in_dest[3:2];

  assign full_c = (count_q == CNT_FULL);
  assign push_c = in_valid && !full_c;
  // Entries leave the FIFO only while the FSM is idle.
  assign pop_c  = (state_q == ST_IDLE) && (count_q != '0);

  // Only the routed port's ready/ack are observed.
  always_comb begin
    sel_rdy_c = 1'b0;
    sel_ack_c = 1'b0;
    case (route_q)
      2'd0: begin
        sel_rdy_c = wr.write_rdy1;
        sel_ack_c = wr.write_ack1;
      end
      2'd1: begin
        sel_rdy_c = wr.write_rdy2;
        sel_ack_c = wr.write_ack2;
      end
      2'd2: begin
        sel_rdy_c = wr.write_rdy3;
        sel_ack_c = wr.write_ack3;
      end
      default: begin
        sel_rdy_c = 1'b0;
        sel_ack_c = 1'b0;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_data_d  = mem_data_q;
    mem_route_d = mem_route_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push_c) begin
      mem_data_d[wr_ptr_q]  = in_data;
      mem_route_d[wr_ptr_q] = in_dest[1:0];
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Handshake FSM, output data register and status.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    route_d      = route_q;
    wen_d        = wen_q;
    drop_count_d = drop_count_q;
    // A full FIFO refuses the input even if an entry leaves this cycle.
    overflow_d   = overflow_q | (in_valid & full_c);

    case (state_q)
      ST_IDLE: begin
        if (pop_c) begin
          data_d  = mem_data_q[rd_ptr_q];
          route_d = mem_route_q[rd_ptr_q];
          if (mem_route_q[rd_ptr_q] == ROUTE_DROP) begin
            if (drop_count_q != 8'hFF) begin
              drop_count_d = drop_count_q + 8'd1;
            end
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (sel_rdy_c) begin
          wen_d   = 3'(3'b001 << route_q);
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Request stays up even if ready drops; only ack completes it.
        if (sel_ack_c) begin
          wen_d   = '0;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        // Wait for ack release so one ack is never counted twice.
        if (!sel_ack_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wen_d   = '0;
      end
    endcase

    busy_d     = (count_d != '0) || (state_d != ST_IDLE);
    in_ready_d = (count_d != CNT_FULL);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      route_q      <= '0;
      wen_q        <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      for (int i = 0; i < int'(fifo_depth); i++) begin
        mem_route_q[i] <= '0;
        for (int j = 0; j < int'(num_inputs); j++) begin
          mem_data_q[i][j] <= '0;
        end
      end
      for (int j = 0; j < int'(num_inputs); j++) begin
        data_q[j] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      route_q      <= route_d;
      wen_q        <= wen_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      mem_route_q  <= mem_route_d;
      mem_data_q   <= mem_data_d;
      data_q       <= data_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_count_q;
  assign wr.write_en1   = wen_q[0];
  assign wr.write_en2   = wen_q[1];
  assign wr.write_en3   = wen_q[2];
  assign wr.w_data_out1 = data_q;
  assign wr.w_data_out2 = data_q;
  assign wr.w_data_out3 = data_q[0];

endmodule

// File: tb/tb_v_tile_writer.sv
// Self-checking bench for v_tile_writer: directed scenarios plus a randomized
// run scored against an in-order queue model of the expected port writes.
`timescale 1ns/1ps
module tb_v_tile_writer;
  localparam int unsigned W = 16;
  localparam int unsigned N = 4;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data [N];
  logic [3:0]   in_dest;
  logic         in_ready;
  logic         busy;
  logic         overflow;
  logic [7:0]   drop_count;

  v_tile_writer_if #(.width(W), .num_inputs(N)) wr_if ();

  v_tile_writer #(.width(W), .num_inputs(N), .fifo_depth(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_ready   (in_ready),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count),
    .wr         (wr_if)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Downstream port model controls
  logic [2:0] rdy_level  = 3'b000;
  bit         ack_enable = 1'b1;
  bit         rand_mode  = 1'b0;
  int         ack_len    = 1;

  // Observed writes, in order of request assertion
  int          obs_port[$];
  logic [63:0] obs_data[$];
  logic [2:0]  en_prev = '0;
  int          hold [3];
  logic [63:0] cap [3];
  int multi_err = 0, rise_ack_err = 0, stab_err = 0, early_fall_err = 0;

  function automatic logic [63:0] port_data(input int p);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (p == 0) v[W*i +: W] = wr_if.w_data_out1[i];
      else if (p == 1) v[W*i +: W] = wr_if.w_data_out2[i];
    end
    if (p == 2) v = {48'd0, wr_if.w_data_out3};
    return v;
  endfunction

  // Downstream tile model: records writes, checks protocol, answers with acks.
  always @(negedge clk) begin
    logic [2:0] en_now;
    logic [2:0] ack_cur;
    en_now  = {wr_if.write_en3, wr_if.write_en2, wr_if.write_en1};
    ack_cur = {wr_if.write_ack3, wr_if.write_ack2, wr_if.write_ack1};
    if (reset) begin
      en_prev = '0;
      ack_cur = '0;
      for (int p = 0; p < 3; p++) hold[p] = 0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (en_now[p] && !en_prev[p]) begin
          cap[p] = port_data(p);
          obs_port.push_back(p);
          obs_data.push_back(cap[p]);
          if (ack_cur[p]) rise_ack_err++;
        end else if (en_now[p] && port_data(p) !== cap[p]) begin
          stab_err++;
        end
        if (!en_now[p] && en_prev[p] && !ack_cur[p]) early_fall_err++;
        if (ack_cur[p]) begin
          if (hold[p] <= 1) ack_cur[p] = 1'b0;
          else hold[p] = hold[p] - 1;
        end else if (en_now[p] && ack_enable) begin
          ack_cur[p] = 1'b1;
          hold[p] = rand_mode ? int'($urandom_range(1, 3)) : ack_len;
        end
      end
      if ($countones(en_now) > 1) multi_err++;
      en_prev = en_now;
    end
    wr_if.write_ack1 = ack_cur[0];
    wr_if.write_ack2 = ack_cur[1];
    wr_if.write_ack3 = ack_cur[2];
    wr_if.write_rdy1 = rand_mode ? 1'($urandom_range(0, 1)) : rdy_level[0];
    wr_if.write_rdy2 = rand_mode ? 1'($urandom_range(0, 1)) : rdy_level[1];
    wr_if.write_rdy3 = rand_mode ? 1'($urandom_range(0, 1)) : rdy_level[2];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] route, input logic [63:0] vec);
    in_valid = 1'b1;
    in_dest  = {2'($urandom_range(0, 3)), route};
    for (int i = 0; i < int'(N); i++) in_data[i] = vec[W*i +: W];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clear_obs();
    obs_port.delete();
    obs_data.delete();
  endtask

  task automatic test_reset();
    logic [2:0] ens;
    in_valid = 1'b0;
    in_dest  = '0;
    for (int i = 0; i < int'(N); i++) in_data[i] = '0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #3;
    ens = {wr_if.write_en3, wr_if.write_en2, wr_if.write_en1};
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests_run++;
    if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    tests_run++;
    if (ens !== 3'b000) begin tests_failed++; $display("FAIL reset_write_en: got %b want 000", ens); end
    tests_run++;
    if (port_data(0) !== 64'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", port_data(0)); end
    do_reset();
    tick(1);
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_status: ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_port1();
    bit ok;
    logic [63:0] vec;
    vec = 64'h0007_0005_0003_0001;
    rdy_level = 3'b001; ack_len = 1; ack_enable = 1'b1; rand_mode = 1'b0;
    tick(2);
    clear_obs();
    push(2'd0, vec);
    tick(1);
    tests_run++;
    if (wr_if.write_en1 !== 1'b0) begin tests_failed++; $display("FAIL p1_en_early: got %b want 0", wr_if.write_en1); end
    tick(1);
    tests_run++;
    if (wr_if.write_en1 !== 1'b1) begin tests_failed++; $display("FAIL p1_en_rise: got %b want 1", wr_if.write_en1); end
    tests_run++;
    if (port_data(0) !== vec) begin tests_failed++; $display("FAIL p1_data: got %h want %h", port_data(0), vec); end
    tests_run++;
    if ({wr_if.write_en3, wr_if.write_en2} !== 2'b00) begin
      tests_failed++; $display("FAIL p1_other_en: got %b want 00", {wr_if.write_en3, wr_if.write_en2});
    end
    tick(1);
    tests_run++;
    if (wr_if.write_en1 !== 1'b0) begin tests_failed++; $display("FAIL p1_en_fall: got %b want 0", wr_if.write_en1); end
    wait_idle(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL p1_idle: busy=%b want 0 within 20 cycles", busy); end
    tests_run++;
    if (obs_port.size() != 1 || obs_port[0] != 0 || obs_data[0] !== vec) begin
      tests_failed++; $display("FAIL p1_writes: got %0d writes want 1 on port1", obs_port.size());
    end
  endtask

  task automatic test_config();
    bit ok;
    logic [63:0] vec;
    vec = {$urandom, 16'($urandom), 16'h0000};
    rdy_level = 3'b100; ack_len = 1;
    tick(2);
    clear_obs();
    push(2'd2, vec);
    wait_idle(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL cfg_idle: busy=%b want 0 within 20 cycles", busy); end
    tests_run++;
    if (obs_port.size() != 1 || obs_port[0] != 2 || obs_data[0] !== 64'd0) begin
      tests_failed++; $display("FAIL cfg_write: got %0d writes (first port %0d data %h) want 1 on port3 data 0",
                               obs_port.size(), (obs_port.size() > 0) ? obs_port[0] : -1,
                               (obs_data.size() > 0) ? obs_data[0] : 64'd0);
    end
    tests_run++;
    if (port_data(0) !== vec) begin tests_failed++; $display("FAIL cfg_data_reg: got %h want %h", port_data(0), vec); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [63:0] exp_v [5];
    rdy_level = 3'b101; ack_len = 3;
    tick(2);
    clear_obs();
    // One entry moves into the output register, the next four fill the FIFO.
    for (int k = 0; k < 5; k++) begin
      exp_v[k] = {$urandom, $urandom};
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_%0d: got %b want 1", k, in_ready); end
      push(2'd1, exp_v[k]);
    end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL bp_no_ovf: got %b want 0", overflow); end
    push(2'd1, {$urandom, $urandom});
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    tests_run++;
    if (obs_port.size() != 0) begin tests_failed++; $display("FAIL bp_stalled: got %0d writes want 0", obs_port.size()); end
    rdy_level = 3'b111;
    wait_idle(200, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bp_idle: busy=%b want 0 within 200 cycles", busy); end
    tests_run++;
    if (obs_port.size() != 5) begin tests_failed++; $display("FAIL bp_count: got %0d writes want 5", obs_port.size()); end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (k >= obs_port.size() || obs_port[k] != 1 || obs_data[k] !== exp_v[k]) begin
        tests_failed++; $display("FAIL bp_order_%0d: want port2 data %h", k, exp_v[k]);
      end
    end
    tests_run++;
    if (rise_ack_err != 0) begin tests_failed++; $display("FAIL bp_en_during_ack: got %0d want 0", rise_ack_err); end
  endtask

  task automatic test_mixed();
    bit ok;
    logic [63:0] a, b, c;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    rdy_level = 3'b011; ack_len = 1;
    tick(2);
    clear_obs();
    push(2'd0, a);
    push(2'd3, b);
    push(2'd1, c);
    wait_idle(50, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL mix_idle: busy=%b want 0 within 50 cycles", busy); end
    tests_run++;
    if (obs_port.size() != 2 || obs_port[0] != 0 || obs_data[0] !== a || obs_port[1] != 1 || obs_data[1] !== c) begin
      tests_failed++; $display("FAIL mix_order: got %0d writes want port1 %h then port2 %h", obs_port.size(), a, c);
    end
    tests_run++;
    if (drop_count !== 8'd1) begin tests_failed++; $display("FAIL mix_drop_count: got %0d want 1", drop_count); end
  endtask

  task automatic test_drop();
    bit ok;
    int not_ready;
    not_ready = 0;
    do_reset();
    rdy_level = 3'b111;
    tick(1);
    clear_obs();
    for (int k = 0; k < 100; k++) begin
      if (!in_ready) not_ready++;
      push(2'd3, {$urandom, $urandom});
    end
    wait_idle(20, ok);
    tests_run++;
    if (drop_count !== 8'd100) begin tests_failed++; $display("FAIL drop_100: got %0d want 100", drop_count); end
    for (int k = 0; k < 200; k++) begin
      if (!in_ready) not_ready++;
      push(2'd3, {$urandom, $urandom});
    end
    wait_idle(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL drop_idle: busy=%b want 0 within 20 cycles", busy); end
    tests_run++;
    if (drop_count !== 8'd255) begin tests_failed++; $display("FAIL drop_saturate: got %0d want 255", drop_count); end
    tests_run++;
    if (obs_port.size() != 0) begin tests_failed++; $display("FAIL drop_no_write: got %0d writes want 0", obs_port.size()); end
    tests_run++;
    if (not_ready != 0 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL drop_flow: not_ready=%0d overflow=%b want 0/0", not_ready, overflow);
    end
  endtask

  task automatic test_reset_mid();
    rdy_level = 3'b001; ack_enable = 1'b0;
    tick(2);
    clear_obs();
    for (int k = 0; k < 6; k++) push(2'd0, {$urandom, $urandom});
    tests_run++;
    if (wr_if.write_en1 !== 1'b1 || overflow !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL rm_setup: en1=%b overflow=%b ready=%b want 1/1/0",
                               wr_if.write_en1, overflow, in_ready);
    end
    reset = 1'b1;
    #2;
    tests_run++;
    if (wr_if.write_en1 !== 1'b0) begin tests_failed++; $display("FAIL rm_en_async: got %b want 0", wr_if.write_en1); end
    tests_run++;
    if (in_ready !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0) begin
      tests_failed++; $display("FAIL rm_status: ready=%b overflow=%b busy=%b drops=%0d want 1/0/0/0",
                               in_ready, overflow, busy, drop_count);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    ack_enable = 1'b1;
    tick(4);
    tests_run++;
    if (busy !== 1'b0 || wr_if.write_en1 !== 1'b0) begin
      tests_failed++; $display("FAIL rm_fifo_empty: busy=%b en1=%b want 0/0", busy, wr_if.write_en1);
    end
  endtask

  task automatic test_random();
    bit ok;
    int exp_p[$];
    logic [63:0] exp_d[$];
    int drops, timeouts, gap, guard, exp_drop;
    logic [1:0] route;
    logic [63:0] vec;
    drops = 0; timeouts = 0;
    do_reset();
    rand_mode = 1'b1; ack_enable = 1'b1;
    clear_obs();
    for (int k = 0; k < 200; k++) begin
      gap = int'($urandom_range(0, 2));
      if (gap > 0) tick(gap);
      guard = 0;
      while (!in_ready && guard < 100) begin
        tick(1);
        guard++;
      end
      if (!in_ready) begin
        timeouts++;
        break;
      end
      route = 2'($urandom_range(0, 3));
      vec   = {$urandom, $urandom};
      push(route, vec);
      if (route == 2'd3) drops++;
      else begin
        exp_p.push_back(int'(route));
        exp_d.push_back((route == 2'd2) ? {48'd0, vec[15:0]} : vec);
      end
    end
    tests_run++;
    if (timeouts != 0) begin tests_failed++; $display("FAIL rnd_ready_timeout: got %0d want 0", timeouts); end
    wait_idle(3000, ok);
    rand_mode = 1'b0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rnd_idle: busy=%b want 0 within 3000 cycles", busy); end
    tests_run++;
    if (obs_port.size() != exp_p.size()) begin
      tests_failed++; $display("FAIL rnd_count: got %0d writes want %0d", obs_port.size(), exp_p.size());
    end
    for (int i = 0; i < exp_p.size(); i++) begin
      tests_run++;
      if (i >= obs_port.size() || obs_port[i] != exp_p[i] || obs_data[i] !== exp_d[i]) begin
        tests_failed++; $display("FAIL rnd_write_%0d: got port %0d data %h want port %0d data %h", i,
                                 (i < obs_port.size()) ? obs_port[i] : -1,
                                 (i < obs_data.size()) ? obs_data[i] : 64'd0, exp_p[i], exp_d[i]);
      end
    end
    exp_drop = (drops > 255) ? 255 : drops;
    tests_run++;
    if (drop_count !== 8'(exp_drop)) begin tests_failed++; $display("FAIL rnd_drops: got %0d want %0d", drop_count, exp_drop); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rnd_overflow: got %b want 0", overflow); end
    tests_run++;
    if (multi_err != 0 || rise_ack_err != 0 || stab_err != 0 || early_fall_err != 0) begin
      tests_failed++; $display("FAIL rnd_protocol: multi=%0d en_in_ack=%0d unstable=%0d early_fall=%0d want all 0",
                               multi_err, rise_ack_err, stab_err, early_fall_err);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_dest  = '0;
    for (int i = 0; i < int'(N); i++) in_data[i] = '0;
    test_reset();
    test_port1();
    test_config();
    test_backpressure();
    test_mixed();
    test_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1);
  end

endmodule
